// File: rtl/core_pkg.sv
// Shared constants and types for the integer register file and its scoreboard.
package core_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;
    localparam int ZERO_IDX  = 0;

    typedef logic [$clog2(NREGS_DEF)-1:0] reg_sel_t;

endpackage : core_pkg

// File: rtl/regfile_sb_bypass.sv
// One read port: selects stored or forwarded data, forces the zero register,
// and reports whether the operand is available this cycle.
module regfile_sb_bypass #(
    parameter int XLEN     = 32,
    parameter int AW       = 5,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic [AW-1:0]   i_sel,
    input  logic [XLEN-1:0] i_reg_data,
    input  logic            i_pending,
    input  logic            i_wen,
    input  logic [AW-1:0]   i_wsel,
    input  logic [XLEN-1:0] i_wdata,
    output logic [XLEN-1:0] o_data,
    output logic            o_ready
);

    logic w_is_zero;
    logic w_hit;

    assign w_is_zero = (ZERO_REG != 0) && (i_sel == '0);
    assign w_hit     = (BYPASS != 0) && i_wen && (i_wsel == i_sel);

    always_comb begin
        o_data = i_reg_data;
        if (w_hit) begin
            o_data = i_wdata;
        end
        // Zero forcing overrides any forwarded writeback.
        if (w_is_zero) begin
            o_data = '0;
        end
        o_ready = !i_pending || w_hit || w_is_zero;
    end

endmodule : regfile_sb_bypass

// File: rtl/regfile_sb.sv
// Integer register file with NRP combinational read ports, one write port and
// a pending-producer scoreboard with busy count and sticky WAW error.
module regfile_sb
    import core_pkg::*;
#(
    parameter  int XLEN     = XLEN_DEF,
    parameter  int NREGS    = NREGS_DEF,
    parameter  int NRP      = 2,
    parameter  int BYPASS   = 1,
    parameter  int ZERO_REG = 1,
    localparam int AW       = $clog2(NREGS)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [NRP*AW-1:0]   read_sel,
    output logic [NRP*XLEN-1:0] read_data,
    output logic [NRP-1:0]      read_ready,
    input  logic                issue_en,
    input  logic [AW-1:0]       issue_sel,
    input  logic                wEn,
    input  logic [AW-1:0]       write_sel,
    input  logic [XLEN-1:0]     write_data,
    output logic [AW:0]         busy_count,
    output logic                waw_err
);

    logic [XLEN-1:0]  r_regs [NREGS];
    logic [NREGS-1:0] r_pend;
    logic [AW:0]      r_busy;
    logic             r_waw;

    logic             w_wr_ok;
    logic             w_iss_ok;
    logic             w_waw_hit;
    logic [NREGS-1:0] w_pend_nxt;
    logic [AW:0]      w_busy_nxt;

    assign w_wr_ok  = wEn && !((ZERO_REG != 0) && (write_sel == AW'(ZERO_IDX)));
    assign w_iss_ok = issue_en && !((ZERO_REG != 0) && (issue_sel == AW'(ZERO_IDX)));
    // A writeback to the same register in the same cycle retires the old
    // producer, so the new issue is legal.
    assign w_waw_hit = w_iss_ok && r_pend[issue_sel] && !(wEn && (write_sel == issue_sel));

    always_comb begin
        w_pend_nxt = r_pend;
        if (w_wr_ok) begin
            w_pend_nxt[write_sel] = 1'b0;
        end
        if (w_iss_ok) begin
            w_pend_nxt[issue_sel] = 1'b1;
        end
        w_busy_nxt = '0;
        for (int i = 0; i < NREGS; i++) begin
            w_busy_nxt = w_busy_nxt + (AW+1)'(w_pend_nxt[i]);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
            r_pend <= '0;
            r_busy <= '0;
            r_waw  <= 1'b0;
        end else begin
            if (w_wr_ok) begin
                r_regs[write_sel] <= write_data;
            end
            r_pend <= w_pend_nxt;
            r_busy <= w_busy_nxt;
            if (w_waw_hit) begin
                r_waw <= 1'b1;
            end
        end
    end

    assign busy_count = r_busy;
    assign waw_err    = r_waw;

    for (genvar gi = 0; gi < NRP; gi++) begin : g_rd
        logic [AW-1:0]   w_sel;
        logic [XLEN-1:0] w_val;
        logic            w_pnd;

        assign w_sel = read_sel[gi*AW +: AW];
        assign w_val = r_regs[w_sel];
        assign w_pnd = r_pend[w_sel];

        regfile_sb_bypass #(
            .XLEN     (XLEN),
            .AW       (AW),
            .BYPASS   (BYPASS),
            .ZERO_REG (ZERO_REG)
        ) u_port (
            .i_sel      (w_sel),
            .i_reg_data (w_val),
            .i_pending  (w_pnd),
            .i_wen      (wEn),
            .i_wsel     (write_sel),
            .i_wdata    (write_data),
            .o_data     (read_data[gi*XLEN +: XLEN]),
            .o_ready    (read_ready[gi])
        );
    end

endmodule : regfile_sb

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: a bypassing and a non-bypassing instance share
// the same stimulus; outputs are sampled between clock edges.
module tb_regfile_sb;
    import core_pkg::*;

    localparam int XLEN = 32;
    localparam int AW   = 5;
    localparam int NRP  = 2;

    logic                clock;
    logic                reset;
    logic [NRP*AW-1:0]   read_sel;
    logic                issue_en;
    logic [AW-1:0]       issue_sel;
    logic                wEn;
    logic [AW-1:0]       write_sel;
    logic [XLEN-1:0]     write_data;

    logic [NRP*XLEN-1:0] b_data, n_data;
    logic [NRP-1:0]      b_ready, n_ready;
    logic [AW:0]         b_busy, n_busy;
    logic                b_waw, n_waw;

    int n_total = 0;
    int n_pass  = 0;

    regfile_sb #(.BYPASS(1)) u_byp (
        .clock(clock), .reset(reset), .read_sel(read_sel), .read_data(b_data),
        .read_ready(b_ready), .issue_en(issue_en), .issue_sel(issue_sel), .wEn(wEn),
        .write_sel(write_sel), .write_data(write_data), .busy_count(b_busy), .waw_err(b_waw)
    );

    regfile_sb #(.BYPASS(0)) u_nob (
        .clock(clock), .reset(reset), .read_sel(read_sel), .read_data(n_data),
        .read_ready(n_ready), .issue_en(issue_en), .issue_sel(issue_sel), .wEn(wEn),
        .write_sel(write_sel), .write_data(write_data), .busy_count(n_busy), .waw_err(n_waw)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic sel(input reg_sel_t s0, input reg_sel_t s1);
        read_sel = {s1, s0};
    endtask

    initial begin
        reset = 1'b0; read_sel = '0; issue_en = 1'b0; issue_sel = '0;
        wEn = 1'b0; write_sel = '0; write_data = '0;
        #23;
        chk("rst_busy", 64'(b_busy), 64'd0);
        chk("rst_waw", 64'(b_waw), 64'd0);
        reset = 1'b1;
        tick();

        for (int r = 0; r < 32; r++) begin
            sel(reg_sel_t'(r), reg_sel_t'(31 - r));
            #1;
            chk($sformatf("rst_read_b%0d", r), b_data, 64'd0);
            chk($sformatf("rst_read_n%0d", r), n_data, 64'd0);
            chk($sformatf("rst_ready%0d", r), 64'(b_ready), 64'd3);
        end
        chk("init_busy", 64'(b_busy), 64'd0);
        chk("init_waw", 64'(b_waw), 64'd0);

        // Write 5 while reading it on port 0 and register 1 on port 1.
        tick();
        wEn = 1'b1; write_sel = 5'd5; write_data = 32'hDEADBEEF; sel(5'd5, 5'd1);
        #1;
        chk("byp_same_cycle", b_data, 64'h00000000_DEADBEEF);
        chk("nob_same_cycle_old", n_data, 64'd0);
        tick();
        wEn = 1'b0;
        #1;
        chk("nob_next_cycle", n_data, 64'h00000000_DEADBEEF);
        chk("byp_next_cycle", b_data, 64'h00000000_DEADBEEF);

        // Register 0 is hardwired: writes discarded, issues ignored.
        wEn = 1'b1; write_sel = 5'd0; write_data = 32'h1234; sel(5'd0, 5'd5);
        #1;
        chk("zero_bypass_forced", b_data, 64'hDEADBEEF_00000000);
        tick();
        wEn = 1'b0; issue_en = 1'b1; issue_sel = 5'd0;
        #1;
        chk("zero_after_write", b_data, 64'hDEADBEEF_00000000);
        chk("zero_after_write_nob", n_data, 64'hDEADBEEF_00000000);
        tick();
        issue_en = 1'b0;
        #1;
        chk("zero_issue_busy", 64'(b_busy), 64'd0);
        chk("zero_issue_waw", 64'(b_waw), 64'd0);
        chk("zero_ready", 64'(b_ready), 64'd3);

        // Issue 7, then write it back.
        issue_en = 1'b1; issue_sel = 5'd7;
        tick();
        issue_en = 1'b0; sel(5'd7, 5'd5);
        #1;
        chk("iss7_ready_byp", 64'(b_ready), 64'b10);
        chk("iss7_ready_nob", 64'(n_ready), 64'b10);
        chk("iss7_busy", 64'(b_busy), 64'd1);
        wEn = 1'b1; write_sel = 5'd7; write_data = 32'h55;
        #1;
        chk("wb7_ready_byp", 64'(b_ready), 64'b11);
        chk("wb7_data_byp", b_data, 64'hDEADBEEF_00000055);
        chk("wb7_ready_nob", 64'(n_ready), 64'b10);
        chk("wb7_busy_same", 64'(b_busy), 64'd1);
        tick();
        wEn = 1'b0;
        #1;
        chk("wb7_busy_next", 64'(b_busy), 64'd0);
        chk("wb7_ready_nob_next", 64'(n_ready), 64'b11);
        chk("wb7_data_nob_next", n_data, 64'hDEADBEEF_00000055);

        // Issue 9, then issue and writeback 9 together, then a real WAW.
        issue_en = 1'b1; issue_sel = 5'd9;
        tick();
        chk("iss9_busy", 64'(b_busy), 64'd1);
        wEn = 1'b1; write_sel = 5'd9; write_data = 32'h99;
        tick();
        wEn = 1'b0; issue_en = 1'b0; sel(5'd9, 5'd9);
        #1;
        chk("same9_busy", 64'(b_busy), 64'd1);
        chk("same9_waw", 64'(b_waw), 64'd0);
        chk("same9_ready", 64'(b_ready), 64'b00);
        chk("same9_data", b_data, {32'h99, 32'h99});
        issue_en = 1'b1;
        tick();
        issue_en = 1'b0;
        #1;
        chk("waw_set", 64'(b_waw), 64'd1);
        chk("waw_set_nob", 64'(n_waw), 64'd1);
        chk("waw_busy", 64'(b_busy), 64'd1);
        tick();
        tick();
        chk("waw_sticky", 64'(b_waw), 64'd1);

        // Three pending plus a written register, then asynchronous reset.
        issue_en = 1'b1; issue_sel = 5'd3;
        tick();
        issue_sel = 5'd4; wEn = 1'b1; write_sel = 5'd10; write_data = 32'hA5A5_0F0F;
        tick();
        issue_en = 1'b0; wEn = 1'b0; sel(5'd10, 5'd3);
        #1;
        chk("pre_rst_busy", 64'(b_busy), 64'd3);
        chk("pre_rst_data", b_data, 64'hA5A5_0F0F);
        chk("pre_rst_ready", 64'(b_ready), 64'b01);
        #1;
        reset = 1'b0;
        #1;
        chk("async_busy", 64'(b_busy), 64'd0);
        chk("async_waw", 64'(b_waw), 64'd0);
        chk("async_data", b_data, 64'd0);
        chk("async_ready", 64'(b_ready), 64'b11);
        sel(5'd5, 5'd9);
        #1;
        chk("async_data2", b_data, 64'd0);
        chk("async_ready2", 64'(n_ready), 64'b11);
        tick();
        chk("held_busy", 64'(n_busy), 64'd0);
        reset = 1'b1;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_regfile_sb
